// File: rtl/clock_pkg.sv
// Shared types and helpers for the multi-alarm clock.
// Time is carried as a packed H:M:S record.
package clock_pkg;

  localparam logic [5:0] MAX_HOUR    = 6'd23;
  localparam logic [5:0] MAX_MIN_SEC = 6'd59;

  typedef struct packed {
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
  } hms_t;

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } ring_state_t;

  function automatic logic hms_valid(hms_t t);
    return (t.hour <= MAX_HOUR) &&
           (t.minute <= MAX_MIN_SEC) &&
           (t.second <= MAX_MIN_SEC);
  endfunction

  // mins <= 59, so at most one hour carry
  function automatic hms_t hms_add_minutes(hms_t t, logic [5:0] mins);
    hms_t       r;
    logic [6:0] sum;
    r   = t;
    sum = {1'b0, t.minute} + {1'b0, mins};
    if (sum > 7'd59) begin
      r.minute = 6'(sum - 7'd60);
      r.hour   = (t.hour == MAX_HOUR) ? 6'd0 : t.hour + 6'd1;
    end else begin
      r.minute = sum[5:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/hms_counter.sv
// Clock divider plus 24-hour H:M:S carry chain.
// A load replaces the time, clears the divider and suppresses tick.
module hms_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_load,
  input  hms_t i_load_val,
  output hms_t o_time,
  output logic o_tick
);

  localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_HZ - 1);

  logic [DW-1:0] r_div;
  hms_t          r_time;
  logic          r_tick;
  hms_t          w_next;

  always_comb begin
    w_next = r_time;
    if (r_time.second == MAX_MIN_SEC) begin
      w_next.second = 6'd0;
      if (r_time.minute == MAX_MIN_SEC) begin
        w_next.minute = 6'd0;
        w_next.hour   = (r_time.hour == MAX_HOUR) ?
                        6'd0 : r_time.hour + 6'd1;
      end else begin
        w_next.minute = r_time.minute + 6'd1;
      end
    end else begin
      w_next.second = r_time.second + 6'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div  <= '0;
      r_time <= '0;
      r_tick <= 1'b0;
    end else if (i_load) begin
      r_div  <= '0;
      r_time <= i_load_val;
      r_tick <= 1'b0;
    end else if (i_run && r_div == DIV_LAST) begin
      r_div  <= '0;
      r_time <= w_next;
      r_tick <= 1'b1;
    end else begin
      r_tick <= 1'b0;
      if (i_run) r_div <= r_div + 1'b1;
    end
  end

  assign o_time = r_time;
  assign o_tick = r_tick;

endmodule

// File: rtl/multi_alarm_clock.sv
// Timekeeping core with NUM_ALARMS alarm slots and a
// ring/snooze state machine with auto-timeout.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int NUM_ALARMS     = 4,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  localparam int IDXW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  CLK_50,
  input  logic                  reset_en,
  input  logic                  run_en,
  input  logic                  set_time_en,
  input  logic [5:0]            hour_set,
  input  logic [5:0]            minute_set,
  input  logic [5:0]            second_set,
  input  logic                  alarm_wr,
  input  logic [IDXW-1:0]       alarm_idx,
  input  logic                  alarm_on,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [5:0]            hour,
  output logic [5:0]            minute,
  output logic [5:0]            second,
  output logic                  tick,
  output logic                  ringing,
  output logic [IDXW-1:0]       ring_idx,
  output logic [NUM_ALARMS-1:0] alarm_active
);

  localparam logic [7:0] RING_CNT = 8'(RING_SECONDS);
  localparam logic [5:0] SNZ_MIN  = 6'(SNOOZE_MINUTES);

  hms_t w_set;
  logic w_set_ok;
  logic w_load;
  logic w_wr;
  hms_t w_time;
  logic w_tick;

  assign w_set    = '{hour: hour_set, minute: minute_set,
                      second: second_set};
  assign w_set_ok = hms_valid(w_set);
  assign w_load   = set_time_en && w_set_ok;
  assign w_wr     = alarm_wr && w_set_ok &&
                    (int'(alarm_idx) < NUM_ALARMS);

  hms_counter #(.CLK_HZ(CLK_HZ)) u_cnt (
    .i_clk      (CLK_50),
    .i_rst      (reset_en),
    .i_run      (run_en),
    .i_load     (w_load),
    .i_load_val (w_set),
    .o_time     (w_time),
    .o_tick     (w_tick)
  );

  hms_t                  r_slot [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_en;

  always_ff @(posedge CLK_50) begin
    if (reset_en) begin
      for (int i = 0; i < NUM_ALARMS; i++) r_slot[i] <= '0;
      r_en <= '0;
    end else if (w_wr) begin
      r_slot[alarm_idx] <= w_set;
      r_en[alarm_idx]   <= alarm_on;
    end
  end

  // Scan downward so the lowest matching slot is kept
  logic            w_hit;
  logic [IDXW-1:0] w_hit_idx;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (r_en[i] && r_slot[i] == w_time) begin
        w_hit     = 1'b1;
        w_hit_idx = IDXW'(i);
      end
    end
  end

  ring_state_t     r_state, w_state_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  hms_t            r_target, w_target_nxt;
  logic [IDXW-1:0] r_idx, w_idx_nxt;

  always_ff @(posedge CLK_50) begin
    if (reset_en) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_target <= '0;
      r_idx    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_target <= w_target_nxt;
      r_idx    <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_idx_nxt    = r_idx;
    unique case (r_state)
      IDLE: begin
        if (w_tick && w_hit) begin
          w_state_nxt = RING;
          w_idx_nxt   = w_hit_idx;
          w_cnt_nxt   = RING_CNT;
        end
      end
      RING: begin
        if (dismiss) begin
          w_state_nxt = IDLE;
        end else if (snooze) begin
          w_state_nxt  = SNOOZE;
          w_target_nxt = hms_add_minutes(w_time, SNZ_MIN);
        end else if (w_tick) begin
          w_cnt_nxt = r_cnt - 8'd1;
          if (r_cnt <= 8'd1) w_state_nxt = IDLE;
        end
      end
      SNOOZE: begin
        if (dismiss) begin
          w_state_nxt = IDLE;
        end else if (w_tick && w_time == r_target) begin
          w_state_nxt = RING;
          w_cnt_nxt   = RING_CNT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign hour         = w_time.hour;
  assign minute       = w_time.minute;
  assign second       = w_time.second;
  assign tick         = w_tick;
  assign ringing      = (r_state == RING);
  assign ring_idx     = r_idx;
  assign alarm_active = r_en;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Bench for multi_alarm_clock: directed table, slot-range
// checks on a 5-slot instance, then random traffic vs a model.
module tb_multi_alarm_clock;

  localparam int CLK_HZ = 4;
  localparam int NA     = 4;
  localparam int RS     = 3;
  localparam int SM     = 5;
  localparam int DAY    = 86400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_rst = 0, i_run = 0, i_set = 0;
  logic [5:0] i_h = 0, i_m = 0, i_s = 0;
  logic       i_wr = 0, i_on = 0, i_snz = 0, i_dis = 0;
  logic [1:0] i_idx = 0;
  logic       i_wr5 = 0;
  logic [2:0] i_idx5 = 0;

  logic [5:0] o_h, o_m, o_s;
  logic       o_tick, o_ring;
  logic [1:0] o_ridx;
  logic [3:0] o_act;
  logic [5:0] p_h, p_m, p_s;
  logic       p_tick, p_ring;
  logic [2:0] p_ridx;
  logic [4:0] p_act;

  multi_alarm_clock #(
    .CLK_HZ(CLK_HZ), .NUM_ALARMS(NA),
    .RING_SECONDS(RS), .SNOOZE_MINUTES(SM)
  ) dut (
    .CLK_50(clk), .reset_en(i_rst), .run_en(i_run),
    .set_time_en(i_set), .hour_set(i_h),
    .minute_set(i_m), .second_set(i_s),
    .alarm_wr(i_wr), .alarm_idx(i_idx), .alarm_on(i_on),
    .snooze(i_snz), .dismiss(i_dis),
    .hour(o_h), .minute(o_m), .second(o_s), .tick(o_tick),
    .ringing(o_ring), .ring_idx(o_ridx), .alarm_active(o_act)
  );

  multi_alarm_clock #(
    .CLK_HZ(CLK_HZ), .NUM_ALARMS(5),
    .RING_SECONDS(RS), .SNOOZE_MINUTES(SM)
  ) dut5 (
    .CLK_50(clk), .reset_en(i_rst), .run_en(i_run),
    .set_time_en(i_set), .hour_set(i_h),
    .minute_set(i_m), .second_set(i_s),
    .alarm_wr(i_wr5), .alarm_idx(i_idx5), .alarm_on(i_on),
    .snooze(i_snz), .dismiss(i_dis),
    .hour(p_h), .minute(p_m), .second(p_s), .tick(p_tick),
    .ringing(p_ring), .ring_idx(p_ridx), .alarm_active(p_act)
  );

  // Reference model: time as seconds-of-day, mode 0/1/2
  int m_sec = 0, m_div = 0, m_mode = 0, m_cnt = 0;
  int m_tgt = 0, m_idx = 0;
  bit m_tick = 0;
  int m_al [NA];
  bit m_en [NA];

  int n_vec = 0, n_bad = 0;

  function automatic logic [3:0] m_act();
    logic [3:0] a;
    for (int i = 0; i < NA; i++) a[i] = m_en[i];
    return a;
  endfunction

  task automatic step();
    int ns, nd, nmode, ncnt, ntgt, nidx, hit, setsec;
    bit ntick, ok;
    logic [17:0] got, exp;
    ok = (int'(i_h) <= 23) && (int'(i_m) <= 59) &&
         (int'(i_s) <= 59);
    setsec = int'(i_h) * 3600 + int'(i_m) * 60 + int'(i_s);
    ns = m_sec; nd = m_div; ntick = 0;
    if (i_set && ok) begin
      ns = setsec; nd = 0;
    end else if (i_run) begin
      if (m_div == CLK_HZ - 1) begin
        nd = 0; ns = (m_sec + 1) % DAY; ntick = 1;
      end else begin
        nd = m_div + 1;
      end
    end
    hit = -1;
    if (m_tick)
      for (int i = NA - 1; i >= 0; i--)
        if (m_en[i] && m_al[i] == m_sec) hit = i;
    nmode = m_mode; ncnt = m_cnt; ntgt = m_tgt; nidx = m_idx;
    case (m_mode)
      0: if (hit >= 0) begin
        nmode = 1; nidx = hit; ncnt = RS;
      end
      1: if (i_dis) nmode = 0;
        else if (i_snz) begin
          nmode = 2; ntgt = (m_sec + SM * 60) % DAY;
        end else if (m_tick) begin
          ncnt = m_cnt - 1;
          if (ncnt == 0) nmode = 0;
        end
      default: if (i_dis) nmode = 0;
        else if (m_tick && m_sec == m_tgt) begin
          nmode = 1; ncnt = RS;
        end
    endcase
    @(posedge clk);
    #1;
    if (i_rst) begin
      m_sec = 0; m_div = 0; m_tick = 0; m_mode = 0;
      m_cnt = 0; m_tgt = 0; m_idx = 0;
      for (int i = 0; i < NA; i++) begin
        m_al[i] = 0; m_en[i] = 0;
      end
    end else begin
      if (i_wr && ok) begin
        m_al[i_idx] = setsec; m_en[i_idx] = i_on;
      end
      m_sec = ns; m_div = nd; m_tick = ntick;
      m_mode = nmode; m_cnt = ncnt; m_tgt = ntgt; m_idx = nidx;
    end
    n_vec++;
    got = {o_h, o_m, o_s};
    exp = {6'(m_sec / 3600), 6'((m_sec / 60) % 60),
           6'(m_sec % 60)};
    if (got != exp || o_tick != m_tick ||
        o_ring != (m_mode == 1) || o_ridx != 2'(m_idx) ||
        o_act != m_act()) begin
      n_bad++;
      $display("FAIL model t=%0t got %0d:%0d:%0d tk%0b r%0b i%0d a%b req %0d:%0d:%0d tk%0b r%0b i%0d a%b",
               $time, o_h, o_m, o_s, o_tick, o_ring, o_ridx, o_act,
               exp[17:12], exp[11:6], exp[5:0], m_tick,
               m_mode == 1, m_idx, m_act());
    end
    i_rst = 0; i_set = 0; i_wr = 0; i_snz = 0; i_dis = 0;
    i_wr5 = 0;
  endtask

  typedef enum int {
    OP_RST, OP_LOAD, OP_WR, OP_SNZ, OP_DIS, OP_SNZDIS, OP_WAIT
  } op_e;

  typedef struct {
    op_e        op;
    int         h, m, s, idx;
    bit         on;
    int         cyc;
    int         eh, em, es;
    bit         ering;
    int         eidx;
    logic [3:0] eact;
  } vec_t;

  vec_t tbl [$];

  task automatic chk5(string name, logic [4:0] req);
    n_vec++;
    if (p_act !== req) begin
      n_bad++;
      $display("FAIL %s got %b req %b", name, p_act, req);
    end
  endtask

  initial begin
    for (int i = 0; i < NA; i++) begin
      m_al[i] = 0; m_en[i] = 0;
    end
    tbl.push_back('{OP_RST,    0, 0, 0,0,0,   1,  0, 0, 0,0,0,4'b0000});
    tbl.push_back('{OP_LOAD,  23,59,58,0,0,   1, 23,59,58,0,0,4'b0000});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   4, 23,59,59,0,0,4'b0000});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   4,  0, 0, 0,0,0,4'b0000});
    tbl.push_back('{OP_LOAD,  25,10,10,0,0,   1,  0, 0, 0,0,0,4'b0000});
    tbl.push_back('{OP_WR,     7, 0, 0,1,1,   1,  0, 0, 0,0,0,4'b0010});
    tbl.push_back('{OP_WR,     7, 0, 0,3,1,   1,  0, 0, 0,0,0,4'b1010});
    tbl.push_back('{OP_WR,    24, 0, 0,2,1,   1,  0, 0, 1,0,0,4'b1010});
    tbl.push_back('{OP_LOAD,   6,59,59,0,0,   1,  6,59,59,0,0,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   4,  7, 0, 0,0,0,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   1,  7, 0, 0,1,1,4'b1010});
    tbl.push_back('{OP_SNZ,    0, 0, 0,0,0,   1,  7, 0, 0,0,1,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,1198,  7, 5, 0,0,1,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   1,  7, 5, 0,1,1,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,  11,  7, 5, 3,1,1,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   1,  7, 5, 3,0,1,4'b1010});
    tbl.push_back('{OP_LOAD,   6,59,59,0,0,   1,  6,59,59,0,1,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   4,  7, 0, 0,0,1,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   1,  7, 0, 0,1,1,4'b1010});
    tbl.push_back('{OP_SNZDIS, 0, 0, 0,0,0,   1,  7, 0, 0,0,1,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,1199,  7, 5, 0,0,1,4'b1010});
    tbl.push_back('{OP_LOAD,   6,59,59,0,0,   1,  6,59,59,0,1,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   4,  7, 0, 0,0,1,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   1,  7, 0, 0,1,1,4'b1010});
    tbl.push_back('{OP_SNZ,    0, 0, 0,0,0,   1,  7, 0, 0,0,1,4'b1010});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   2,  7, 0, 1,0,1,4'b1010});
    tbl.push_back('{OP_RST,    0, 0, 0,0,0,   1,  0, 0, 0,0,0,4'b0000});
    tbl.push_back('{OP_LOAD,   7, 4,59,0,0,   1,  7, 4,59,0,0,4'b0000});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   5,  7, 5, 0,0,0,4'b0000});
    tbl.push_back('{OP_WR,     7, 5, 2,0,1,   1,  7, 5, 0,0,0,4'b0001});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   6,  7, 5, 2,0,0,4'b0001});
    tbl.push_back('{OP_WAIT,   0, 0, 0,0,0,   1,  7, 5, 2,1,0,4'b0001});
    tbl.push_back('{OP_DIS,    0, 0, 0,0,0,   1,  7, 5, 2,0,0,4'b0001});

    i_run = 1;
    for (int v = 0; v < tbl.size(); v++) begin
      i_h = 6'(tbl[v].h); i_m = 6'(tbl[v].m); i_s = 6'(tbl[v].s);
      i_idx = 2'(tbl[v].idx); i_on = tbl[v].on;
      case (tbl[v].op)
        OP_RST:    i_rst = 1;
        OP_LOAD:   i_set = 1;
        OP_WR:     i_wr = 1;
        OP_SNZ:    i_snz = 1;
        OP_DIS:    i_dis = 1;
        OP_SNZDIS: begin i_snz = 1; i_dis = 1; end
        default:   ;
      endcase
      step();
      for (int k = 1; k < tbl[v].cyc; k++) step();
      n_vec++;
      if (o_h != 6'(tbl[v].eh) || o_m != 6'(tbl[v].em) ||
          o_s != 6'(tbl[v].es) || o_ring != tbl[v].ering ||
          o_ridx != 2'(tbl[v].eidx) || o_act != tbl[v].eact) begin
        n_bad++;
        $display("FAIL tbl[%0d] got %0d:%0d:%0d r%0b i%0d a%b req %0d:%0d:%0d r%0b i%0d a%b",
                 v, o_h, o_m, o_s, o_ring, o_ridx, o_act,
                 tbl[v].eh, tbl[v].em, tbl[v].es, tbl[v].ering,
                 tbl[v].eidx, tbl[v].eact);
      end
    end

    // Slot index range on the 5-slot instance
    i_h = 6'd1; i_m = 6'd2; i_s = 6'd3; i_on = 1;
    i_idx5 = 3'd5; i_wr5 = 1; step();
    chk5("idx5_ignored", 5'b00000);
    i_idx5 = 3'd4; i_wr5 = 1; step();
    chk5("idx4_written", 5'b10000);
    i_idx5 = 3'd7; i_wr5 = 1; step();
    chk5("idx7_ignored", 5'b10000);

    // Random traffic; loads aim just before enabled alarms
    for (int n = 0; n < 6000; n++) begin
      int r, k, t;
      i_run = ($urandom % 16) != 0;
      r = $urandom % 1000;
      if (r < 4) begin
        k = $urandom % NA;
        t = m_en[k] ? m_al[k] : $urandom % DAY;
        t = (t - int'($urandom % 3) + DAY) % DAY;
        i_h = 6'(t / 3600); i_m = 6'((t / 60) % 60);
        i_s = 6'(t % 60);
        if ($urandom % 7 == 0) i_h = 6'(24 + $urandom % 40);
        i_set = 1;
      end else if (r < 10) begin
        t = (m_sec + 1 + int'($urandom % 4)) % DAY;
        i_h = 6'(t / 3600); i_m = 6'((t / 60) % 60);
        i_s = 6'(t % 60);
        if ($urandom % 8 == 0) i_s = 6'(60 + $urandom % 4);
        i_idx = 2'($urandom % NA);
        i_on = ($urandom % 4) != 0;
        i_wr = 1;
      end else if (r < 25) begin
        i_snz = 1;
      end else if (r < 33) begin
        i_dis = 1;
      end else if (r < 35) begin
        i_snz = 1; i_dis = 1;
      end else if (r == 35) begin
        i_rst = 1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
